// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles N_BYTES bytes into one registered word on a valid/ready port, with flush, idle timeout and byte count (clk, rst async active-low, in_data/in_valid/in_ready, flush, out_data/out_count/out_valid/out_ready)
module byte_word_packer #(
  parameter int N_BYTES = 8,
  parameter int BYTE_W = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W = $clog2(N_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BYTE_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [N_BYTES*BYTE_W-1:0] out_data,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int WW = N_BYTES * BYTE_W;
  localparam int IW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);
  localparam logic [IW-1:0] T_MAX = IW'(TIMEOUT_CYC);
  localparam logic [IW-1:0] T_LAST = IW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  logic [CNT_W-1:0] count, lane;
  logic [WW-1:0] asm_reg, asm_next;
  logic [IW-1:0] idle_cnt, idle_next;
  logic flush_pend, flush_next, slot_free, accept, complete, load, idle;
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready = slot_free || (count != LAST && !flush_pend);
    accept = in_valid && in_ready;
    complete = accept && count == LAST;
    load = complete || (flush_pend && slot_free);
    lane = MSB_FIRST ? LAST - count : count;
    asm_next = accept ? asm_reg | (WW'(in_data) << (lane * BYTE_W)) : asm_reg;
    idle = TIMEOUT_CYC > 0 && count != '0 && !accept;
    idle_next = idle ? idle_cnt + IW'(idle_cnt != T_MAX) : '0;
    flush_next = !load && (flush_pend || (flush && (count != '0 || accept)) || (idle && idle_cnt == T_LAST));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      asm_reg <= '0;
      flush_pend <= 1'b0;
      idle_cnt <= '0;
      out_data <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      count <= load ? '0 : count + CNT_W'(accept);
      asm_reg <= load ? '0 : asm_next;
      flush_pend <= flush_next;
      idle_cnt <= idle_next;
      out_data <= load ? asm_next : out_data;
      out_count <= !load ? out_count : complete ? CNT_W'(N_BYTES) : count + CNT_W'(accept);
      out_valid <= load || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer: directed vector table plus multi-cycle sequences for byte_word_packer
module tb_byte_word_packer;
  logic clk, rst, in_valid, flush, out_ready;
  logic [7:0] in_data;
  logic rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [63:0] od0, od1, od2;
  logic [3:0] oc0, oc1, oc2;
  int checks = 0;
  int errors = 0;
  byte_word_packer u0 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .flush(flush), .out_data(od0), .out_count(oc0), .out_valid(ov0), .out_ready(out_ready));
  byte_word_packer #(.MSB_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .flush(flush), .out_data(od1), .out_count(oc1), .out_valid(ov1), .out_ready(out_ready));
  byte_word_packer #(.TIMEOUT_CYC(4)) u2 (.clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
    .flush(flush), .out_data(od2), .out_count(oc2), .out_valid(ov2), .out_ready(out_ready));
  typedef struct {
    logic v;
    logic [7:0] d;
    logic fl;
    logic ordy;
    logic rdy;
    logic ov;
    logic [63:0] od;
    logic [3:0] oc;
  } vec_t;
  vec_t vecs[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic void add(input logic v, input logic [7:0] d, input logic fl, input logic ordy,
                              input logic rdy, input logic ov, input logic [63:0] od, input logic [3:0] oc);
    vecs.push_back('{v, d, fl, ordy, rdy, ov, od, oc});
  endfunction
  task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic ordy, output logic r);
    in_valid = v;
    in_data = d;
    flush = fl;
    out_ready = ordy;
    #1 r = rdy0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  initial begin
    logic r;
    reset_dut();
    chk("reset out_valid", 64'(ov0), 64'd0);
    chk("reset out_data", od0, 64'd0);
    chk("reset out_count", 64'(oc0), 64'd0);
    chk("reset in_ready", 64'(rdy0), 64'd1);
    for (int k = 0; k < 8; k++) add(1'b1, 8'((k + 1) * 17), 1'b0, 1'b1, 1'b1, k == 7, 64'h8877665544332211, 4'd8);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0000000000CCBBAA, 4'd3);
    add(1'b1, 8'hDD, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 64'h00000000000000DD, 4'd1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    for (int k = 0; k < 7; k++) add(1'b1, 8'(k + 1), 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0807060504030201, 4'd8);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 4'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].ordy, r);
      chk($sformatf("vec%0d in_ready", i), 64'(r), 64'(vecs[i].rdy));
      chk($sformatf("vec%0d out_valid", i), 64'(ov0), 64'(vecs[i].ov));
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d out_data", i), od0, vecs[i].od);
        chk($sformatf("vec%0d out_count", i), 64'(oc0), 64'(vecs[i].oc));
      end
    end
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b0, r);
      chk($sformatf("stall byte%0d in_ready", i), 64'(r), 64'd1);
      if (i >= 7) begin
        chk($sformatf("stall byte%0d out_valid", i), 64'(ov0), 64'd1);
        chk($sformatf("stall byte%0d word0", i), od0, 64'h0807060504030201);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h10, 1'b0, 1'b0, r);
      chk("stall last in_ready", 64'(r), 64'd0);
      chk("stall hold word0", od0, 64'h0807060504030201);
      chk("stall hold count", 64'(oc0), 64'd8);
    end
    step(1'b1, 8'h10, 1'b0, 1'b1, r);
    chk("release in_ready", 64'(r), 64'd1);
    chk("release out_valid", 64'(ov0), 64'd1);
    chk("release word1", od0, 64'h100F0E0D0C0B0A09);
    step(1'b0, 8'h00, 1'b0, 1'b1, r);
    chk("release drained", 64'(ov0), 64'd0);
    reset_dut();
    for (int k = 0; k < 8; k++) step(1'b1, 8'((k + 1) * 17), 1'b0, 1'b1, r);
    chk("msb_first out_valid", 64'(ov1), 64'd1);
    chk("msb_first out_data", od1, 64'h1122334455667788);
    chk("msb_first out_count", 64'(oc1), 64'd8);
    reset_dut();
    step(1'b1, 8'h01, 1'b0, 1'b1, r);
    step(1'b1, 8'h02, 1'b0, 1'b1, r);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, r);
      chk($sformatf("timeout idle%0d flush_pend", i), 64'(u2.flush_pend), 64'd0);
      chk($sformatf("timeout idle%0d out_valid", i), 64'(ov2), 64'd0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, r);
    chk("timeout flush_pend", 64'(u2.flush_pend), 64'd1);
    chk("timeout early out_valid", 64'(ov2), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1, r);
    chk("timeout out_valid", 64'(ov2), 64'd1);
    chk("timeout out_data", od2, 64'h0000000000000201);
    chk("timeout out_count", 64'(oc2), 64'd2);
    chk("no timeout when disabled", 64'(ov0), 64'd0);
    reset_dut();
    for (int k = 0; k < 13; k++) step(1'b1, 8'hF0 + 8'(k), 1'b0, 1'b0, r);
    chk("pre-reset out_valid", 64'(ov0), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async reset out_valid", 64'(ov0), 64'd0);
    chk("async reset out_data", od0, 64'd0);
    chk("async reset out_count", 64'(oc0), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 8; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b1, r);
    chk("post-reset out_valid", 64'(ov0), 64'd1);
    chk("post-reset out_data", od0, 64'hA7A6A5A4A3A2A1A0);
    chk("post-reset out_count", 64'(oc0), 64'd8);
    step(1'b0, 8'h00, 1'b0, 1'b1, r);
    chk("post-reset drained", 64'(ov0), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
